// File: rtl/button_event_if.sv
// ----------------------------------------------------------------------------
// button_event_if
//   Signal bundle between the push-button controller and its user.
//
//   btn_raw       raw, asynchronous button inputs (1 = pressed)
//   enable        1 = event pulses allowed, 0 = pulses masked
//   btn_level     debounced level per button
//   press_pulse   1-cycle pulse on accepted press
//   release_pulse 1-cycle pulse on accepted release
//   long_pulse    1-cycle pulse when a hold reaches the long-press time
//   repeat_pulse  1-cycle pulse at every auto-repeat period after long_pulse
//   tick          timebase strobe (debug)
//
//   master: the side that owns the buttons and consumes events.
//   slave : the controller itself.
// ----------------------------------------------------------------------------
interface button_event_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0] btn_raw;
    logic             enable;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] press_pulse;
    logic [N_BTN-1:0] release_pulse;
    logic [N_BTN-1:0] long_pulse;
    logic [N_BTN-1:0] repeat_pulse;
    logic             tick;

    modport master (
        output btn_raw, enable,
        input  btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, tick
    );

    modport slave (
        input  btn_raw, enable,
        output btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, tick
    );
endinterface

// File: rtl/button_event_ctrl.sv
// ----------------------------------------------------------------------------
// button_event_ctrl
//   Synchronises and debounces N_BTN push-buttons against a shared tick
//   timebase and emits press / release / long-press / auto-repeat events.
//
//   clk    system clock, rising edge
//   reset  synchronous, active-high reset
//   bus    button_event_if.slave: btn_raw and enable in; btn_level, the four
//          pulse vectors and tick out. All outputs are registered.
// ----------------------------------------------------------------------------
module button_event_ctrl #(
    parameter int N_BTN        = 4,
    parameter int TICK_DIV     = 100000,
    parameter int DEB_TICKS    = 20,
    parameter int LONG_TICKS   = 1000,
    parameter int REPEAT_TICKS = 200
) (
    input  logic          clk,
    input  logic          reset,
    button_event_if.slave bus
);

    localparam int HOLD_MAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int DIV_W    = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
    localparam int DEB_W    = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
    localparam int HOLD_W   = (HOLD_MAX  > 1) ? $clog2(HOLD_MAX)  : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_TICKS - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_TICKS - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_e;

    logic [N_BTN-1:0]  sync_meta, sync_q;
    logic [DIV_W-1:0]  div_q;
    logic              tick_q;

    state_e            state_q [N_BTN];
    state_e            state_d [N_BTN];
    logic [DEB_W-1:0]  deb_q   [N_BTN];
    logic [DEB_W-1:0]  deb_d   [N_BTN];
    logic [HOLD_W-1:0] hold_q  [N_BTN];
    logic [HOLD_W-1:0] hold_d  [N_BTN];

    logic [N_BTN-1:0]  long_fired_q, long_fired_d;
    logic [N_BTN-1:0]  level_q, level_d;
    logic [N_BTN-1:0]  press_d, release_d, long_d, repeat_d;
    logic [N_BTN-1:0]  press_q, release_q, long_q, repeat_q;

    // Two-flop synchroniser and the shared timebase. The tick strobe is
    // registered, so the first one appears TICK_DIV cycles after reset.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would collapse the synchroniser chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= '0;
            sync_q    <= '0;
            div_q     <= '0;
            tick_q    <= 1'b0;
        end else begin
            sync_meta <= bus.btn_raw;
            sync_q    <= sync_meta;
            tick_q    <= (div_q == DIV_LAST);
            div_q     <= (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        end
    end

    // Per-button state register. Pulses are masked by enable on their way
    // into the output flops, so a disabled window simply drops events while
    // the FSMs and btn_level keep tracking the buttons.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the per-button arrays are small register files, not RAM,
            // so each element is cleared explicitly in a loop.
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= IDLE;
                deb_q[i]   <= '0;
                hold_q[i]  <= '0;
            end
            long_fired_q <= '0;
            level_q      <= '0;
            press_q      <= '0;
            release_q    <= '0;
            long_q       <= '0;
            repeat_q     <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= state_d[i];
                deb_q[i]   <= deb_d[i];
                hold_q[i]  <= hold_d[i];
            end
            long_fired_q <= long_fired_d;
            level_q      <= level_d;
            press_q      <= press_d   & {N_BTN{bus.enable}};
            release_q    <= release_d & {N_BTN{bus.enable}};
            long_q       <= long_d    & {N_BTN{bus.enable}};
            repeat_q     <= repeat_d  & {N_BTN{bus.enable}};
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path leaves a value unassigned and no latch is inferred.
        long_fired_d = long_fired_q;
        level_d      = level_q;
        press_d      = '0;
        release_d    = '0;
        long_d       = '0;
        repeat_d     = '0;

        for (int i = 0; i < N_BTN; i++) begin
            state_d[i] = state_q[i];
            deb_d[i]   = deb_q[i];
            hold_d[i]  = hold_q[i];

            case (state_q[i])
                IDLE: begin
                    if (sync_q[i]) begin
                        state_d[i] = PRESS_WAIT;
                        deb_d[i]   = '0;
                    end
                end

                PRESS_WAIT: begin
                    if (!sync_q[i]) begin
                        state_d[i] = IDLE;
                    end else if (tick_q) begin
                        if (deb_q[i] == DEB_LAST) begin
                            state_d[i]      = HELD;
                            level_d[i]      = 1'b1;
                            press_d[i]      = 1'b1;
                            hold_d[i]       = '0;
                            long_fired_d[i] = 1'b0;
                        end else begin
                            deb_d[i] = deb_q[i] + DEB_W'(1);
                        end
                    end
                end

                HELD: begin
                    // hold_cnt is left untouched on the way out so that a
                    // bounce back from RELEASE_WAIT resumes the same hold.
                    if (!sync_q[i]) begin
                        state_d[i] = RELEASE_WAIT;
                        deb_d[i]   = '0;
                    end else if (tick_q) begin
                        if (!long_fired_q[i] && hold_q[i] == LONG_LAST) begin
                            long_d[i]       = 1'b1;
                            long_fired_d[i] = 1'b1;
                            hold_d[i]       = '0;
                        end else if (long_fired_q[i] && hold_q[i] == REP_LAST) begin
                            repeat_d[i] = 1'b1;
                            hold_d[i]   = '0;
                        end else begin
                            hold_d[i] = hold_q[i] + HOLD_W'(1);
                        end
                    end
                end

                RELEASE_WAIT: begin
                    if (sync_q[i]) begin
                        state_d[i] = HELD;
                    end else if (tick_q) begin
                        if (deb_q[i] == DEB_LAST) begin
                            state_d[i]      = IDLE;
                            level_d[i]      = 1'b0;
                            release_d[i]    = 1'b1;
                            long_fired_d[i] = 1'b0;
                        end else begin
                            deb_d[i] = deb_q[i] + DEB_W'(1);
                        end
                    end
                end

                default: state_d[i] = IDLE;
            endcase
        end
    end

    assign bus.btn_level     = level_q;
    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign bus.long_pulse    = long_q;
    assign bus.repeat_pulse  = repeat_q;
    assign bus.tick          = tick_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// ----------------------------------------------------------------------------
// tb_button_event_ctrl
//   Directed + randomised bench for button_event_ctrl with small timing
//   parameters. A behavioural model (tick arithmetic, tick counting per
//   button) predicts every output each cycle; directed phases add checks on
//   counts and spacings of events.
// ----------------------------------------------------------------------------
module tb_button_event_ctrl;

    localparam int N    = 4;
    localparam int TD   = 4;
    localparam int DEB  = 3;
    localparam int LONG = 10;
    localparam int REP  = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    button_event_if #(.N_BTN(N)) bus ();

    button_event_ctrl #(
        .N_BTN        (N),
        .TICK_DIV     (TD),
        .DEB_TICKS    (DEB),
        .LONG_TICKS   (LONG),
        .REPEAT_TICKS (REP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit     m_s1 [N];
    bit     m_s2 [N];
    bit     m_level [N];
    bit     m_pend [N];
    bit     m_long_done [N];
    int     m_cnt [N];
    int     m_hold [N];
    int     m_edges;
    bit     m_tick;
    logic [N-1:0] e_level, e_press, e_rel, e_long, e_rep;
    logic         e_tick;

    // Advances the model by one rising edge using the pre-edge inputs.
    task automatic model_edge(input logic rst, input logic [N-1:0] raw, input logic en);
        logic [N-1:0] p, r, lg, rp;
        logic t, s;
        p = '0; r = '0; lg = '0; rp = '0;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_level[i] = 0; m_pend[i] = 0;
                m_long_done[i] = 0; m_cnt[i] = 0; m_hold[i] = 0;
            end
            m_edges = 0;
            m_tick  = 0;
        end else begin
            t = m_tick;
            for (int i = 0; i < N; i++) begin
                s = m_s2[i];
                if (!m_level[i]) begin
                    if (!m_pend[i]) begin
                        if (s) begin m_pend[i] = 1; m_cnt[i] = 0; end
                    end else if (!s) begin
                        m_pend[i] = 0;
                    end else if (t) begin
                        m_cnt[i]++;
                        if (m_cnt[i] == DEB) begin
                            m_level[i] = 1; m_pend[i] = 0; p[i] = 1;
                            m_hold[i] = 0; m_long_done[i] = 0;
                        end
                    end
                end else begin
                    if (!m_pend[i]) begin
                        if (!s) begin
                            m_pend[i] = 1; m_cnt[i] = 0;
                        end else if (t) begin
                            m_hold[i]++;
                            if (m_hold[i] == (m_long_done[i] ? REP : LONG)) begin
                                if (m_long_done[i]) rp[i] = 1;
                                else lg[i] = 1;
                                m_long_done[i] = 1;
                                m_hold[i] = 0;
                            end
                        end
                    end else if (s) begin
                        m_pend[i] = 0;
                    end else if (t) begin
                        m_cnt[i]++;
                        if (m_cnt[i] == DEB) begin
                            m_level[i] = 0; m_pend[i] = 0; r[i] = 1; m_long_done[i] = 0;
                        end
                    end
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = raw[i];
            end
            m_edges++;
            m_tick = (m_edges % TD == 0);
        end
        for (int i = 0; i < N; i++) e_level[i] = m_level[i];
        e_press = p  & {N{en}};
        e_rel   = r  & {N{en}};
        e_long  = lg & {N{en}};
        e_rep   = rp & {N{en}};
        e_tick  = m_tick;
    endtask

    // ---------------- observation log ----------------
    int cyc = 0;
    int n_press0, n_long0, n_rep0, n_rel0, n_level0, n_low0, n_press_any, n_rel_any;
    int press_cyc, long_cyc, lvl_at_press;
    int rep_q[$];
    logic [N-1:0] last_press_vec;

    task automatic clear_counts();
        n_press0 = 0; n_long0 = 0; n_rep0 = 0; n_rel0 = 0;
        n_level0 = 0; n_low0 = 0; n_press_any = 0; n_rel_any = 0;
        rep_q.delete();
        last_press_vec = '0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            model_edge(reset, bus.btn_raw, bus.enable);
            @(posedge clk);
            #1;
            check("btn_level",     32'(bus.btn_level),     32'(e_level));
            check("press_pulse",   32'(bus.press_pulse),   32'(e_press));
            check("release_pulse", 32'(bus.release_pulse), 32'(e_rel));
            check("long_pulse",    32'(bus.long_pulse),    32'(e_long));
            check("repeat_pulse",  32'(bus.repeat_pulse),  32'(e_rep));
            check("tick",          32'(bus.tick),          32'(e_tick));
            cyc++;
            if (bus.press_pulse[0]) begin
                n_press0++; press_cyc = cyc; lvl_at_press = int'(bus.btn_level[0]);
            end
            if (bus.long_pulse[0]) begin n_long0++; long_cyc = cyc; end
            if (bus.repeat_pulse[0]) begin n_rep0++; rep_q.push_back(cyc); end
            if (bus.release_pulse[0]) n_rel0++;
            if (bus.btn_level[0]) n_level0++; else n_low0++;
            if (bus.press_pulse != '0) begin n_press_any++; last_press_vec = bus.press_pulse; end
            if (bus.release_pulse != '0) n_rel_any++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start, p0, n_after;
        reset = 1'b1;
        bus.btn_raw = '0;
        bus.enable  = 1'b1;
        clear_counts();
        step(3);
        check("reset_all_zero", 32'({bus.btn_level, bus.press_pulse, bus.release_pulse,
                                     bus.long_pulse, bus.repeat_pulse, bus.tick}), 32'd0);
        reset = 1'b0;

        // Bounce shorter than the debounce window is rejected.
        clear_counts();
        for (int k = 0; k < 6; k++) begin
            bus.btn_raw[0] = (k % 2 == 0);
            step(3);
        end
        bus.btn_raw[0] = 1'b0;
        step(12);
        check("bounce_press_count", 32'(n_press0), 32'd0);
        check("bounce_level_high",  32'(n_level0), 32'd0);

        // Clean press.
        clear_counts();
        start = cyc;
        bus.btn_raw[0] = 1'b1;
        step(16);
        check("press_count",      32'(n_press0), 32'd1);
        check("press_latency",    32'((press_cyc - start) <= 15), 32'd1);
        check("level_with_press", 32'(lvl_at_press), 32'd1);

        // Long press then auto-repeat.
        p0 = press_cyc;
        clear_counts();
        step(p0 + 90 - cyc);
        check("long_count",    32'(n_long0), 32'd1);
        check("long_delay",    32'(long_cyc - p0), 32'd40);
        check("repeat_count",  32'(n_rep0), 32'd3);
        check("level_dropped", 32'(n_low0), 32'd0);
        if (rep_q.size() >= 2) begin
            check("first_repeat_gap", 32'(rep_q[0] - long_cyc), 32'd16);
            check("repeat_gap",       32'(rep_q[1] - rep_q[0]), 32'd16);
        end

        // Short release glitches fall back to HELD; repeats resume.
        clear_counts();
        bus.btn_raw[0] = 1'b0; step(2);
        bus.btn_raw[0] = 1'b1; step(1);
        bus.btn_raw[0] = 1'b0; step(2);
        bus.btn_raw[0] = 1'b1; step(50);
        check("glitch_no_release", 32'(n_rel0), 32'd0);
        check("glitch_repeats",    32'(n_rep0 >= 2), 32'd1);
        n_after = rep_q.size();
        if (n_after >= 2)
            check("glitch_repeat_gap", 32'(rep_q[n_after-1] - rep_q[n_after-2]), 32'd16);

        // Release with bounce.
        clear_counts();
        bus.btn_raw[0] = 1'b0; step(3);
        bus.btn_raw[0] = 1'b1; step(3);
        bus.btn_raw[0] = 1'b0; step(20);
        check("release_count",       32'(n_rel0), 32'd1);
        check("release_no_press",    32'(n_press0), 32'd0);
        check("release_level_final", 32'(bus.btn_level[0]), 32'd0);

        // Simultaneous presses.
        clear_counts();
        bus.btn_raw = 4'b1010;
        step(16);
        check("concurrent_press_cycles", 32'(n_press_any), 32'd1);
        check("concurrent_press_vec",    32'(last_press_vec), 32'h0000000a);
        bus.btn_raw = '0;
        step(20);

        // Masked events, tracking continues.
        clear_counts();
        bus.enable  = 1'b0;
        bus.btn_raw = 4'b1010;
        step(16);
        check("masked_press_cycles", 32'(n_press_any), 32'd0);
        check("masked_level",        32'(bus.btn_level), 32'h0000000a);
        bus.enable = 1'b1;

        // Reset in the middle of a hold.
        reset = 1'b1;
        bus.btn_raw = '0;
        step(1);
        check("midhold_reset_zero", 32'({bus.btn_level, bus.press_pulse, bus.release_pulse,
                                         bus.long_pulse, bus.repeat_pulse}), 32'd0);
        reset = 1'b0;
        clear_counts();
        step(15);
        check("reset_no_release", 32'(n_rel_any), 32'd0);
        check("reset_level_low",  32'(bus.btn_level), 32'd0);
        bus.btn_raw = 4'b1010;
        step(16);
        check("fresh_press_cycles", 32'(n_press_any), 32'd1);
        check("fresh_press_level",  32'(bus.btn_level), 32'h0000000a);

        // Random segments of held patterns with occasional masking.
        for (int seg = 0; seg < 30; seg++) begin
            bus.btn_raw = N'($urandom);
            bus.enable  = ($urandom_range(0, 5) != 0);
            step($urandom_range(2, 60));
        end
        bus.enable = 1'b1;
        bus.btn_raw = '0;
        step(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_event_ctrl.md
Name: button_event_ctrl

Overview:
- Multi-button input controller that sits between the board push-buttons and the game/control logic.
- Synchronises N raw buttons and debounces them with one shared millisecond timebase.
- Runs a per-button state machine that emits single-cycle press, release, long-press and auto-repeat events, plus a clean level per button.

Parameters:
- N_BTN, 4, number of buttons handled.
- TICK_DIV, 100000, clk cycles per timebase tick (1 ms at 100 MHz).
- DEB_TICKS, 20, ticks a new level must stay stable before it is accepted.
- LONG_TICKS, 1000, ticks of accepted hold before long_pulse fires.
- REPEAT_TICKS, 200, tick period of repeat_pulse after long_pulse.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- btn_raw  in  N_BTN  asynchronous raw button inputs, 1 = pressed.
- enable  in  1  1 = event pulses allowed; 0 = pulses masked, tracking continues.
- btn_level  out  N_BTN  debounced level per button.
- press_pulse  out  N_BTN  1-cycle pulse on accepted press.
- release_pulse  out  N_BTN  1-cycle pulse on accepted release.
- long_pulse  out  N_BTN  1-cycle pulse when hold reaches LONG_TICKS.
- repeat_pulse  out  N_BTN  1-cycle pulse every REPEAT_TICKS after long_pulse.
- tick  out  1  timebase strobe, for debug.

Behaviour:
- Reset, synchronous and active-high:
  - All outputs go to 0.
  - Sync flops, tick counter and every per-button counter go to 0.
  - All FSMs go to IDLE and long_fired is cleared.
  - No release_pulse is produced by a reset, even mid-hold.
- Synchroniser: 2 flops per bit; sync[i] lags btn_raw[i] by 2 clk.
- Timebase:
  - div counts 0..TICK_DIV-1 and wraps.
  - tick=1 for exactly one cycle when div==TICK_DIV-1.
  - The first tick comes TICK_DIV cycles after reset is released.
- Per-button FSM. Each button has a deb_cnt, a hold_cnt and a long_fired flag. All outputs are registered.
  - IDLE (level 0):
    - sync=1 → PRESS_WAIT, deb_cnt=0.
  - PRESS_WAIT:
    - sync=0 → IDLE, no event.
    - Otherwise deb_cnt increments on each tick.
    - On the tick at which deb_cnt==DEB_TICKS-1 → HELD; btn_level=1; press_pulse=1 for one cycle; hold_cnt=0; long_fired=0.
  - HELD (level 1):
    - sync=0 → RELEASE_WAIT, deb_cnt=0; hold_cnt freezes.
    - Otherwise hold_cnt increments per tick.
    - If long_fired=0 and hold_cnt reaches LONG_TICKS-1 on a tick: long_pulse=1, long_fired=1, hold_cnt=0.
    - If long_fired=1 and hold_cnt reaches REPEAT_TICKS-1 on a tick: repeat_pulse=1, hold_cnt=0.
  - RELEASE_WAIT (level stays 1):
    - sync=1 → HELD, with hold_cnt and long_fired preserved (a bounce is not a new press).
    - Otherwise deb_cnt increments per tick.
    - At DEB_TICKS-1 on a tick → IDLE; btn_level=0; release_pulse=1; long_fired=0.
- Minimum press latency: 2 clk (sync) + DEB_TICKS ticks, with the pulse 1 clk after the qualifying tick edge.
- The first tick seen after entering a wait state counts, even if it is partial.
- enable=0:
  - Pulse outputs are forced to 0; events in that window are dropped, not queued.
  - btn_level and the FSMs keep running.
- Buttons are fully independent. Any combination of pulses may assert in the same cycle. press_pulse and release_pulse never assert together for the same bit.
- Counter widths: clog2 of the respective maximum. No counter saturates past its terminal value.

Test Plan:
Sim parameters: TICK_DIV=4, DEB_TICKS=3, LONG_TICKS=10, REPEAT_TICKS=4, N_BTN=4.
1. Bounce reject: toggle btn_raw[0] every 3 clk, 5 times, ending at 0 → btn_level and all pulses stay 0 throughout.
2. Clean press: btn_raw[0] 0→1 and held → exactly one press_pulse[0] within 2+3·4+1 ≤ 15 clk; btn_level[0]=1 from the same cycle.
3. Long/repeat: keep btn_raw[0]=1 → long_pulse[0] once, 40 clk (10 ticks) after press_pulse; then repeat_pulse[0] every 16 clk; btn_level[0] stays 1.
4. Release with bounce:
   - Toggle 1→0→1→0 at 3-clk spacing, then hold 0 → exactly one release_pulse[0]; btn_level[0]=0 afterward; no second press_pulse.
   - A 1-cycle glitch to 1 during RELEASE_WAIT returns the FSM to HELD, and repeat continues at the 16-clk cadence.
5. Concurrency and enable:
   - btn_raw=4'b1010 applied simultaneously → press_pulse==4'b1010 in one cycle.
   - Repeat with enable=0 → press_pulse stays 0 while btn_level becomes 4'b1010.
6. Reset mid-hold: assert reset for 1 clk during HELD → all outputs 0 the cycle after; no release_pulse; a fresh press is required to re-raise btn_level.
